// File: rtl/egress_drain_monitor_pkg.sv
// rtl/egress_drain_monitor_pkg.sv - shared types and constants for the egress drain monitor
package egress_drain_monitor_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] IDX_D0   = 2'd0;
    localparam logic [1:0] IDX_D1   = 2'd1;
    localparam logic [1:0] IDX_TOT  = 2'd2;
    localparam logic [1:0] IDX_RSVD = 2'd3;

    localparam int DEF_BW    = 6;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/egress_drain_monitor_rr_arb2.sv
// rtl/egress_drain_monitor_rr_arb2.sv - two-requester round-robin arbiter with one-hot grant
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio=0 favours requester 0 on a tie, prio=1 favours requester 1
    logic prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/egress_drain_monitor.sv
// rtl/egress_drain_monitor.sv - drains two destination FIFOs round-robin and counts drained words
module egress_drain_monitor
    import egress_drain_monitor_pkg::*;
#(
    parameter int BW    = DEF_BW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             drain_en,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    output logic [BW-1:0]    out_data,
    output logic             out_valid,
    output logic             out_dest,
    input  logic             cnt_req,
    input  logic [1:0]       cnt_idx,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_valid,
    input  logic             cnt_clear
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic   draining;
    logic   prev_rd0, prev_rd1;
    logic   pend_valid, pend_dest;
    logic [1:0] req, gnt;
    logic [CNT_W-1:0] cnt0, cnt1, cnt_tot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (drain_en)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (!drain_en) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        draining = (state == ST_DRAIN);
    end

    // a FIFO popped last cycle has a stale empty flag, so it sits out one cycle
    assign req[0] = draining && !D0_empty && !prev_rd0;
    assign req[1] = draining && !D1_empty && !prev_rd1;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign D0_rd = gnt[0];
    assign D1_rd = gnt[1];

    // pop in N -> data valid in N+1 -> captured and presented in N+2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_rd0   <= 1'b0;
            prev_rd1   <= 1'b0;
            pend_valid <= 1'b0;
            pend_dest  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_dest   <= 1'b0;
        end else begin
            prev_rd0   <= D0_rd;
            prev_rd1   <= D1_rd;
            pend_valid <= D0_rd | D1_rd;
            pend_dest  <= D1_rd;
            out_valid  <= pend_valid;
            if (pend_valid) begin
                out_data <= pend_dest ? D1_data_out : D0_data_out;
                out_dest <= pend_dest;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0    <= '0;
            cnt1    <= '0;
            cnt_tot <= '0;
        end else if (cnt_clear) begin
            cnt0    <= '0;
            cnt1    <= '0;
            cnt_tot <= '0;
        end else if (out_valid) begin
            cnt_tot <= cnt_tot + CNT_ONE;
            if (out_dest) cnt1 <= cnt1 + CNT_ONE;
            else          cnt0 <= cnt0 + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
        end else begin
            cnt_valid <= cnt_req;
            if (cnt_req) begin
                case (cnt_idx)
                    IDX_D0:  cnt_data <= cnt0;
                    IDX_D1:  cnt_data <= cnt1;
                    IDX_TOT: cnt_data <= cnt_tot;
                    default: cnt_data <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_egress_drain_monitor.sv
// tb/tb_egress_drain_monitor.sv - randomized self-checking bench for egress_drain_monitor
module tb_egress_drain_monitor;

    localparam int BW    = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             drain_en = 1'b0;
    logic             D0_empty = 1'b1;
    logic             D1_empty = 1'b1;
    logic [BW-1:0]    D0_data_out = '0;
    logic [BW-1:0]    D1_data_out = '0;
    logic             D0_rd, D1_rd;
    logic [BW-1:0]    out_data;
    logic             out_valid, out_dest;
    logic             cnt_req = 1'b0;
    logic [1:0]       cnt_idx = 2'd0;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_valid;
    logic             cnt_clear = 1'b0;

    egress_drain_monitor #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .drain_en    (drain_en),
        .D0_empty    (D0_empty),
        .D1_empty    (D1_empty),
        .D0_data_out (D0_data_out),
        .D1_data_out (D1_data_out),
        .D0_rd       (D0_rd),
        .D1_rd       (D1_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_dest    (out_dest),
        .cnt_req     (cnt_req),
        .cnt_idx     (cnt_idx),
        .cnt_data    (cnt_data),
        .cnt_valid   (cnt_valid),
        .cnt_clear   (cnt_clear)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: values the DUT should show during the current cycle
    bit m_drain, m_busy0, m_busy1, m_fav1;
    bit m_pv, m_pd, m_ov, m_od, m_cv;
    int m_odata, m_cdata;
    int c0, c1, ct;
    int pops;

    task automatic model_reset();
        m_drain = 0; m_busy0 = 0; m_busy1 = 0; m_fav1 = 0;
        m_pv = 0; m_pd = 0; m_ov = 0; m_od = 0; m_cv = 0;
        m_odata = 0; m_cdata = 0;
        c0 = 0; c1 = 0; ct = 0;
    endtask

    // mode 0: D0 only, 1: both full with fixed data, 2: random, 3: idle, 4: counter reads
    task automatic step(input int mode);
        bit e0, e1, g0, g1;
        @(negedge clk);
        D0_data_out = BW'($urandom);
        D1_data_out = BW'($urandom);
        cnt_req     = ($urandom_range(0, 3) == 0);
        cnt_idx     = 2'($urandom);
        cnt_clear   = 1'b0;
        case (mode)
            0: begin drain_en = 1; D0_empty = 0; D1_empty = 1; end
            1: begin drain_en = 1; D0_empty = 0; D1_empty = 0; D0_data_out = 6'h11; D1_data_out = 6'h22; end
            2: begin
                drain_en  = ($urandom_range(0, 7) != 0);
                D0_empty  = ($urandom_range(0, 3) == 0);
                D1_empty  = ($urandom_range(0, 3) == 0);
                cnt_clear = ($urandom_range(0, 47) == 0);
            end
            3: begin drain_en = 0; D0_empty = 1'($urandom); D1_empty = 1'($urandom); end
            default: begin drain_en = 0; D0_empty = 1; D1_empty = 1; cnt_req = 1; end
        endcase
        #1;
        e0 = !D0_empty && !m_busy0;
        e1 = !D1_empty && !m_busy1;
        g0 = 0; g1 = 0;
        if (m_drain) begin
            if (e0 && e1) begin g1 = m_fav1; g0 = !m_fav1; end
            else begin g0 = e0; g1 = e1; end
        end
        check("d0_rd", 32'(D0_rd), 32'(g0));
        check("d1_rd", 32'(D1_rd), 32'(g1));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_data", 32'(out_data), 32'(m_odata));
            check("out_dest", 32'(out_dest), 32'(m_od));
        end
        check("cnt_valid", 32'(cnt_valid), 32'(m_cv));
        if (m_cv) check("cnt_data", 32'(cnt_data), 32'(m_cdata));
        // advance to what the next cycle should show
        m_cv = cnt_req;
        if (cnt_req) m_cdata = (cnt_idx == 0) ? c0 : (cnt_idx == 1) ? c1 : (cnt_idx == 2) ? ct : 0;
        if (cnt_clear) begin
            c0 = 0; c1 = 0; ct = 0;
        end else if (m_ov) begin
            ct = (ct + 1) % (1 << CNT_W);
            if (m_od) c1 = (c1 + 1) % (1 << CNT_W);
            else      c0 = (c0 + 1) % (1 << CNT_W);
        end
        m_ov = m_pv;
        if (m_pv) begin
            m_odata = m_pd ? int'(D1_data_out) : int'(D0_data_out);
            m_od    = m_pd;
        end
        m_pv = g0 | g1;
        m_pd = g1;
        m_busy0 = g0;
        m_busy1 = g1;
        if (g0 | g1) begin
            m_fav1 = g0;
            pops++;
        end
        m_drain = drain_en;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0_rd"}, 32'(D0_rd), 32'd0);
        check({tag, "_d1_rd"}, 32'(D1_rd), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_dest"}, 32'(out_dest), 32'd0);
        check({tag, "_cnt_valid"}, 32'(cnt_valid), 32'd0);
        check({tag, "_cnt_data"}, 32'(cnt_data), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; drain_en = 0; cnt_req = 0; cnt_clear = 0;
        #1;
        check_all_zero("rst");
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_reset();
        pops = 0;
        #1;
        check_all_zero("por");
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 24; i++) step(0);
        for (int i = 0; i < 24; i++) step(1);
        do_reset();
        for (int i = 0; i < 8; i++) step(3);
        for (int i = 0; i < 1500; i++) step(2);
        for (int i = 0; i < 3; i++) step(3);
        for (int i = 0; i < 8; i++) step(4);
        step(0);
        do_reset();
        for (int i = 0; i < 6; i++) step(3);
        for (int i = 0; i < 300; i++) step(1);
        for (int i = 0; i < 3; i++) step(3);
        for (int i = 0; i < 8; i++) step(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
